// File: rtl/decoder_cs_fsm.sv
// decoder_cs_fsm: registered active-low chip-select decoder with wait-state DTACK generation.
// Optional bus-error timeout on undecoded strobes is enabled by defining DECODER_BERR_EN.
module decoder_cs_fsm #(
  parameter int SEL_WIDTH   = 3,
  parameter int WAIT_CYCLES = 2
`ifdef DECODER_BERR_EN
  , parameter int BERR_TIMEOUT = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_WIDTH-1:0]      a,
  input  logic                      e1_n,
  input  logic                      e2_n,
  input  logic                      e3,
  input  logic                      as_n,
  output logic [2**SEL_WIDTH-1:0]   cs_n,
  output logic                      dtack_n,
  output logic                      busy
`ifdef DECODER_BERR_EN
  , output logic                    berr_n
`endif
);
  localparam int N  = 2**SEL_WIDTH;
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic en, start;
  assign en = ~e1_n & ~e2_n & e3;
`ifdef DECODER_BERR_EN
  localparam int TW = $clog2(BERR_TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  // a pending bus error blocks any decode until the strobe is released
  assign start = ~as_n & en & berr_n;
`else
  assign start = ~as_n & en;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cs_n    <= '1;
      dtack_n <= 1'b1;
      busy    <= 1'b0;
      cnt     <= '0;
`ifdef DECODER_BERR_EN
      berr_n  <= 1'b1;
      tcnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef DECODER_BERR_EN
          if (as_n) begin
            tcnt   <= '0;
            berr_n <= 1'b1;
          end else if (en && berr_n) begin
            tcnt <= '0;
          end else if (berr_n) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TW'(BERR_TIMEOUT - 1)) berr_n <= 1'b0;
          end
`endif
          if (start) begin
            cs_n    <= ~(N'(1) << a);
            cnt     <= CW'(WAIT_CYCLES);
            busy    <= 1'b1;
            dtack_n <= (WAIT_CYCLES != 0);
            state   <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (as_n) begin
            cs_n  <= '1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              dtack_n <= 1'b0;
              state   <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (as_n) begin
            cs_n    <= '1;
            dtack_n <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
